des_cmd_sequencer: RTL
======================

Name: des_cmd_sequencer

Overview:
Host-side initiator for the 3DES control unit's 3-bit mode command bus. It takes a start request and an op select, then drives the mode codes for a full job in order: clear, counted byte load, wait for core completion, and byte-by-byte unload. It bridges host valid/ready byte streams onto the control unit's single-cycle mode commands, so the host never sequences mode codes directly.

Parameters:
NBYTES, 8, bytes per block loaded and unloaded; 1..15
TIMEOUT, 1024, max cycles in WAIT for core_done before error abort
TW, 11, width of timeout counter; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle job request; sampled in IDLE only
op  in  2  job type; sampled with start: 0->mode 1, 1->mode 2, 2->mode 3, 3->mode 4
abort  in  1  synchronous abort, any state
in_data  in  8  host load byte
in_valid  in  1  host load byte valid
in_ready  out  1  sequencer accepts in_data
core_done  in  1  core finished processing (level or pulse)
core_data  in  8  head byte of core output shift register
mode  out  3  registered command to control unit; 0 = no-op
load_data  out  8  registered byte presented with load mode codes
out_data  out  8  host unload byte
out_valid  out  1  out_data valid
out_ready  in  1  host accepts out_data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on successful job completion
err  out  1  sticky timeout flag; cleared on next accepted start
byte_cnt  out  4  bytes transferred in current LOAD/UNLOAD phase

Behaviour:
- Reset (async): state=IDLE; mode=0, load_data=0, byte_cnt=0, in_ready=0, out_valid=0, busy=0, done=0, err=0; op latch=0, timer=0.
- mode and load_data are registered: an event decided in cycle N appears on mode in cycle N+1 for exactly one cycle, then returns to 0 unless reissued.
- IDLE: start=1 latches op, clears err -> CLEAR. start=1 in any other state is ignored.
- CLEAR: issue mode=5 once; byte_cnt<=0 -> LOAD.
- LOAD: in_ready = (byte_cnt < NBYTES). On in_valid&&in_ready: next-cycle mode = op code (1..4), load_data = in_data, byte_cnt++. No handshake -> mode=0. Back-to-back bytes allowed, one per cycle. On the handshake that makes byte_cnt==NBYTES -> WAIT with timer=0.
- WAIT: mode=0. core_done=1 -> UNLOAD_PRESENT with byte_cnt<=0. Otherwise timer++; timer==TIMEOUT-1 with no core_done -> err<=1 -> CLEAR_ABORT.
- UNLOAD_PRESENT: out_valid=1, out_data=core_data (combinational pass-through). On out_ready: next-cycle mode=6, byte_cnt++ -> UNLOAD_SHIFT.
- UNLOAD_SHIFT: out_valid=0. Exactly one cycle while mode=6 is on the bus. Then -> UNLOAD_PRESENT if byte_cnt<NBYTES, else DONE. Minimum byte period: 2 cycles.
- DONE: done=1 for one cycle, mode=0 -> IDLE.
- abort=1 in any non-IDLE state -> CLEAR_ABORT. abort takes priority over a simultaneous handshake; that byte is not counted and issues no mode.
- CLEAR_ABORT: issue mode=5 once, byte_cnt<=0, no done -> IDLE. abort in IDLE does nothing.
- Mode codes 0 and 7 are never driven except mode=0 as idle. Only one nonzero mode is issued per cycle.
- Reset mid-job returns to IDLE immediately. No clear command is issued; the control unit is reset by the same n_rst.

Test Plan:
- Encrypt job, op=0, 8 host bytes 0x11..0x88 back-to-back -> mode sequence 5, then 1 x8 with load_data 0x11..0x88 on consecutive cycles. After core_done, 8 unload bytes each followed by mode=6. done pulses once; byte_cnt=8 at end.
- Host stalls: in_valid toggled every other cycle, op=1 -> mode=2 appears only in cycles after a handshake; zeros between; exactly 8 mode=2 cycles.
- Timeout: core_done held 0 with TIMEOUT=16 -> err=1 after 16 WAIT cycles, then mode=5 once, return to IDLE, no done. Next start clears err.
- Unload backpressure: out_ready low 5 cycles on byte 3 -> out_valid and out_data stay stable; no mode=6 until accepted; total mode=6 count = 8.
- Abort during LOAD at byte 4, coincident with in_valid -> that byte is not counted. mode=5 next cycle, then IDLE; in_ready=0.
- start asserted while busy, and async reset mid-UNLOAD -> start ignored. Reset forces mode=0, busy=0, and state IDLE within the same cycle.

Source files
------------

// File: rtl/des_cmd_sequencer.sv
// des_cmd_sequencer
// Host-side initiator for the 3DES control unit's 3-bit mode command bus.
// A single start request runs a whole job: clear, counted byte load, wait
// for the core, then byte-by-byte unload with a shift command per byte.
// Every command on o_mode is registered and lasts exactly one cycle; the
// cycle in which a command is visible is the cycle after it was decided.

module des_cmd_sequencer #(
    parameter int NBYTES  = 8,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic       i_abort,
    input  logic [7:0] i_in_data,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic       i_core_done,
    input  logic [7:0] i_core_data,
    output logic [2:0] o_mode,
    output logic [7:0] o_load_data,
    output logic [7:0] o_out_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [3:0] o_byte_cnt
);

    localparam logic [2:0]    MODE_NOP   = 3'd0;
    localparam logic [2:0]    MODE_CLEAR = 3'd5;
    localparam logic [2:0]    MODE_SHIFT = 3'd6;
    localparam logic [3:0]    LP_NBYTES  = 4'(NBYTES);
    localparam logic [3:0]    LP_LAST    = 4'(NBYTES - 1);
    localparam logic [TW-1:0] LP_TLAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_CLEAR          = 3'd1,
        ST_LOAD           = 3'd2,
        ST_WAIT           = 3'd3,
        ST_UNLOAD_PRESENT = 3'd4,
        ST_UNLOAD_SHIFT   = 3'd5,
        ST_DONE           = 3'd6,
        ST_CLEAR_ABORT    = 3'd7
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_mode;
    logic [7:0]      r_load_data;
    logic [3:0]      r_byte_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    // Job sequencer: state, command bus and all status outputs are registered
    // here. Handshake flags (in_ready/out_valid) are set on entry to the state
    // that owns them so they are already valid in that state's first cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_op        <= 2'd0;
            r_timer     <= '0;
            r_mode      <= MODE_NOP;
            r_load_data <= 8'd0;
            r_byte_cnt  <= 4'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Commands and the done strobe are one-cycle events unless reissued.
            r_mode <= MODE_NOP;
            r_done <= 1'b0;
            if ((r_state != ST_IDLE) && i_abort) begin
                // Abort wins over any handshake in the same cycle: that byte is
                // neither counted nor commanded.
                r_state     <= ST_CLEAR_ABORT;
                r_mode      <= MODE_CLEAR;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_op    <= i_op;
                            r_err   <= 1'b0;
                            r_mode  <= MODE_CLEAR;
                            r_busy  <= 1'b1;
                            r_state <= ST_CLEAR;
                        end else begin
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        r_byte_cnt <= 4'd0;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (i_in_valid && r_in_ready) begin
                            // op 0..3 maps onto load codes 1..4
                            r_mode      <= {1'b0, r_op} + 3'd1;
                            r_load_data <= i_in_data;
                            r_byte_cnt  <= r_byte_cnt + 4'd1;
                            if (r_byte_cnt == LP_LAST) begin
                                r_in_ready <= 1'b0;
                                r_timer    <= '0;
                                r_state    <= ST_WAIT;
                            end else begin
                                r_state    <= ST_LOAD;
                            end
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_WAIT: begin
                        if (i_core_done) begin
                            r_byte_cnt  <= 4'd0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_UNLOAD_PRESENT;
                        end else if (r_timer == LP_TLAST) begin
                            r_err   <= 1'b1;
                            r_mode  <= MODE_CLEAR;
                            r_state <= ST_CLEAR_ABORT;
                        end else begin
                            r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_UNLOAD_PRESENT: begin
                        if (i_out_ready) begin
                            r_mode      <= MODE_SHIFT;
                            r_byte_cnt  <= r_byte_cnt + 4'd1;
                            r_out_valid <= 1'b0;
                            r_state     <= ST_UNLOAD_SHIFT;
                        end else begin
                            r_state     <= ST_UNLOAD_PRESENT;
                        end
                    end
                    ST_UNLOAD_SHIFT: begin
                        // Hold one cycle so the shift lands before the next
                        // head byte is presented.
                        if (r_byte_cnt < LP_NBYTES) begin
                            r_out_valid <= 1'b1;
                            r_state     <= ST_UNLOAD_PRESENT;
                        end else begin
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    ST_CLEAR_ABORT: begin
                        r_byte_cnt <= 4'd0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: begin
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_mode      = r_mode;
    assign o_load_data = r_load_data;
    assign o_byte_cnt  = r_byte_cnt;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    // Head of the core's output shift register goes straight to the host.
    assign o_out_data  = i_core_data;

endmodule
